alu_scheduler: RTL and testbench
================================

ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 The module SHALL have parameter IDLE_SEL, default 4'b1100, which is the alu_sel value driven whenever no operation is executing.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have ports reqN_valid, input, 1 bit (N=0,1): requester N presents an operation.
REQ-005 The module SHALL have ports reqN_ready, output, 1 bit: the scheduler accepts requester N's operation this cycle.
REQ-006 The module SHALL have ports reqN_a and reqN_b, input, 8 bits each: operands.
REQ-007 The module SHALL have ports reqN_sel, input, 4 bits: ALU opcode (0000 add through 1101 pass b).
REQ-008 The module SHALL have ports rspN_valid, output, 1 bit: result available for requester N.
REQ-009 The module SHALL have ports rspN_ready, input, 1 bit: requester N consumes the result.
REQ-010 The module SHALL have ports rspN_data, output, 8 bits: result.
REQ-011 The module SHALL have ports rspN_flags, output, 3 bits: {z,c,o}.
REQ-012 The module SHALL have ports alu_a, alu_b, output, 8 bits, and alu_sel, output, 4 bits: drive to the shared combinational ALU.
REQ-013 The module SHALL have ports alu_out, input, 8 bits, and alu_z, alu_c, alu_o, input, 1 bit each: returned from the shared ALU.
REQ-014 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-016 IDLE SHALL grant exactly one valid requester: reqG_ready=1 for the granted requester only, combinationally from the valids and the priority pointer.
REQ-017 Acceptance SHALL occur on reqG_valid&&reqG_ready; a, b and sel SHALL be registered, the grant ID SHALL be recorded, and the next state SHALL be EXEC.
REQ-018 EXEC SHALL last exactly one cycle and drive alu_a/alu_b/alu_sel from the registers; alu_out and the flags SHALL be captured at the end of the cycle, with next state RESP.
REQ-019 RESP SHALL hold rspG_valid=1 with stable data and flags until rspG_ready=1, then return to IDLE.
REQ-020 Latency: accept in cycle N SHALL give rspG_valid first high in cycle N+2; peak throughput SHALL be one operation per 3 cycles.
REQ-021 reqN_ready SHALL be 0 in EXEC and RESP, and the response to the non-granted requester SHALL stay 0.
REQ-022 Outside EXEC, alu_sel SHALL be IDLE_SEL and alu_a/alu_b SHALL be 0.
REQ-023 Opcodes 1110/1111 SHALL be forwarded unchanged; the captured result (0, z=1) SHALL be returned without error.
REQ-024 Simultaneous valids: the pointer SHALL decide; a lone valid SHALL be granted regardless of the pointer.
REQ-025 The pointer SHALL update only on the RESP handshake, to point at the requester not just served.
REQ-026 A requester dropping valid before acceptance SHALL lose nothing; no state SHALL change.

Reset
REQ-027 On rst=1 at a clock edge, the state SHALL go to IDLE, the pointer SHALL be 0, and all operand/result registers SHALL be 0.
REQ-028 After reset, reqN_ready, rspN_valid, rspN_data, rspN_flags and busy SHALL be 0, and alu_sel SHALL be IDLE_SEL.
REQ-029 Reset in EXEC or RESP SHALL abandon the transaction, and no response SHALL be issued.

Configuration
REQ-030 With ALU_SCHED_RR_EN defined, the pointer SHALL operate as in REQ-024/025 (round-robin).
REQ-031 Without ALU_SCHED_RR_EN, priority SHALL be fixed to requester 0 and the pointer register SHALL be absent.

Verification
REQ-032 req0 add a=0x7F b=0x01 accepted cycle N -> rsp0_valid cycle N+2, data 0x80, flags {0,0,1}.
REQ-033 req0 and req1 both held valid, RR_EN on -> grants alternate 0,1,0,1; without the macro -> req0 always granted.
REQ-034 req1 sub a=0x00 b=0x01 with rsp1_ready low for 5 cycles -> data 0xFF, flags {0,1,0} stable; req0_ready=0 until the handshake.
REQ-035 req0 sel=4'b1111 a=0x55 -> rsp0_data 0x00, flags {1,0,0}.
REQ-036 rst asserted during EXEC -> next cycle IDLE, busy=0, no rspN_valid; a fresh request completes normally.

Source files
------------

// File: rtl/alu_scheduler.sv
// Two-requester front end for a shared combinational ALU: IDLE grants, EXEC drives the ALU, RESP holds the result.
// Optional round-robin arbitration when ALU_SCHED_RR_EN is defined; otherwise requester 0 always has priority.
module alu_scheduler #(
  parameter logic [3:0] IDLE_SEL = 4'b1100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_sel,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  output logic [2:0] rsp0_flags,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic [2:0] rsp1_flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_o,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_nxt;
  logic [1:0] vld;
  logic       gnt, gid_q, acc, rsp_hs;
  logic [7:0] a_q, b_q, res_q;
  logic [3:0] sel_q;
  logic [2:0] flg_q;

  assign vld    = {req1_valid, req0_valid};
  assign acc    = (state == IDLE) && (|vld);
  assign rsp_hs = (state == RESP) && (gid_q ? rsp1_ready : rsp0_ready);

`ifdef ALU_SCHED_RR_EN
  logic ptr_q;
  always_ff @(posedge clk) begin
    if (rst)         ptr_q <= 1'b0;
    else if (rsp_hs) ptr_q <= ~gid_q;
  end
  // Pointer only matters on contention; a lone valid wins outright.
  assign gnt = (&vld) ? ptr_q : vld[1];
`else
  assign gnt = ~vld[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= '0;
      gid_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      if (acc) begin
        a_q   <= gnt ? req1_a   : req0_a;
        b_q   <= gnt ? req1_b   : req0_b;
        sel_q <= gnt ? req1_sel : req0_sel;
        gid_q <= gnt;
      end
      if (state == EXEC) begin
        res_q <= alu_out;
        flg_q <= {alu_z, alu_c, alu_o};
      end
    end
  end

  assign req0_ready = acc && !gnt;
  assign req1_ready = acc &&  gnt;

  // Result lines are gated so the idle requester only ever sees zeros.
  assign rsp0_valid = (state == RESP) && !gid_q;
  assign rsp1_valid = (state == RESP) &&  gid_q;
  assign rsp0_data  = rsp0_valid ? res_q : '0;
  assign rsp0_flags = rsp0_valid ? flg_q : '0;
  assign rsp1_data  = rsp1_valid ? res_q : '0;
  assign rsp1_flags = rsp1_valid ? flg_q : '0;

  assign alu_a   = (state == EXEC) ? a_q   : '0;
  assign alu_b   = (state == EXEC) ? b_q   : '0;
  assign alu_sel = (state == EXEC) ? sel_q : IDLE_SEL;
  assign busy    = (state != IDLE);
endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a small behavioural ALU on the shared port.
module tb_alu_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_sel, req1_sel;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp0_data, rsp1_data;
  logic [2:0] rsp0_flags, rsp1_flags;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_sel;
  logic       alu_z, alu_c, alu_o, busy;
  int         nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  alu_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_z(alu_z), .alu_c(alu_c), .alu_o(alu_o), .busy(busy)
  );

  // add, sub (c = borrow), pass b; any other opcode yields 0
  logic [8:0] t;
  always_comb begin
    t = 9'd0;
    alu_c = 1'b0;
    alu_o = 1'b0;
    case (alu_sel)
      4'b0000: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = t[8];
        alu_o = (alu_a[7] == alu_b[7]) && (t[7] != alu_a[7]);
      end
      4'b0001: begin
        t = {1'b0, alu_a} - {1'b0, alu_b};
        alu_c = t[8];
        alu_o = (alu_a[7] != alu_b[7]) && (t[7] != alu_a[7]);
      end
      4'b1101: t = {1'b0, alu_b};
      default: t = 9'd0;
    endcase
    alu_out = t[7:0];
    alu_z = (t[7:0] == 8'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_rspv", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_data", {rsp1_data, rsp0_data}, 0);
    chk("rst_flags", {rsp1_flags, rsp0_flags}, 0);
    chk("rst_alusel", alu_sel, 4'b1100);
    chk("rst_alua", {alu_a, alu_b}, 0);

    // add 0x7F+0x01, accepted at cycle N
    req0_valid = 1; req0_a = 8'h7F; req0_b = 8'h01; req0_sel = 4'b0000; rsp0_ready = 1;
    #1;
    chk("add_ready0", {req1_ready, req0_ready}, 2'b01);
    step();
    req0_valid = 0;
    #1;
    chk("add_exec_busy", busy, 1);
    chk("add_exec_alu", {alu_a, alu_b, alu_sel}, {8'h7F, 8'h01, 4'b0000});
    chk("add_exec_rspv", rsp0_valid, 0);
    chk("add_exec_ready", {req1_ready, req0_ready}, 0);
    step();
    chk("add_rspv", {rsp1_valid, rsp0_valid}, 2'b01);
    chk("add_data", rsp0_data, 8'h80);
    chk("add_flags", rsp0_flags, 3'b001);
    chk("add_resp_alusel", alu_sel, 4'b1100);
    step();
    chk("add_idle_busy", busy, 0);
    chk("add_idle_rspv", rsp0_valid, 0);
    rsp0_ready = 0;

    // contention: both held valid, both responses consumed immediately
    do_reset();
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    req0_sel = 4'b1101; req0_b = 8'h11; req1_sel = 4'b1101; req1_b = 8'h22;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_SCHED_RR_EN
      automatic logic [1:0] eg = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      automatic logic [1:0] eg = 2'b01;
`endif
      #1;
      chk($sformatf("arb_grant%0d", i), {req1_ready, req0_ready}, eg);
      step(); step();
      chk($sformatf("arb_rspv%0d", i), {rsp1_valid, rsp0_valid}, eg);
      chk($sformatf("arb_data%0d", i), rsp0_data | rsp1_data, eg[1] ? 8'h22 : 8'h11);
      step();
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;

    // sub 0-1 on req1 with a stalled consumer while req0 waits
    do_reset();
    req1_valid = 1; req1_a = 8'h00; req1_b = 8'h01; req1_sel = 4'b0001;
    #1;
    chk("sub_ready1", {req1_ready, req0_ready}, 2'b10);
    step();
    req1_valid = 0; req0_valid = 1; req0_sel = 4'b1101; req0_b = 8'h33;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("sub_hold_v%0d", i), {rsp1_valid, rsp0_valid}, 2'b10);
      chk($sformatf("sub_hold_d%0d", i), {rsp1_data, rsp1_flags}, {8'hFF, 3'b010});
      chk($sformatf("sub_hold_r%0d", i), req0_ready, 0);
      step();
    end
    rsp1_ready = 1;
    #1;
    step();
    rsp1_ready = 0;
    chk("sub_done_busy", busy, 0);
    chk("sub_done_ready0", req0_ready, 1);
    // req0 withdraws before acceptance: nothing should happen
    req0_valid = 0;
    step();
    chk("drop_busy", busy, 0);
    chk("drop_rspv", {rsp1_valid, rsp0_valid}, 0);

    // reserved opcode 1111 passes through and returns zero
    req0_valid = 1; req0_a = 8'h55; req0_b = 8'h00; req0_sel = 4'b1111; rsp0_ready = 1;
    step();
    req0_valid = 0;
    #1;
    chk("op15_alusel", alu_sel, 4'b1111);
    step();
    chk("op15_rsp", {rsp0_valid, rsp0_data, rsp0_flags}, {1'b1, 8'h00, 3'b100});
    step();
    rsp0_ready = 0;

    // reset mid-transaction abandons it
    req0_valid = 1; req0_sel = 4'b0000; req0_a = 8'h01; req0_b = 8'h02; rsp0_ready = 1;
    step();
    req0_valid = 0;
    chk("rst_exec_busy", busy, 1);
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rspv", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_mid_alusel", alu_sel, 4'b1100);
    step();
    chk("rst_mid_rspv2", {rsp1_valid, rsp0_valid}, 0);
    req1_valid = 1; req1_sel = 4'b1101; req1_b = 8'hA5; rsp1_ready = 1;
    #1;
    chk("fresh_ready1", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    chk("fresh_rsp", {rsp1_valid, rsp1_data, rsp1_flags}, {1'b1, 8'hA5, 3'b000});
    step();
    chk("fresh_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
